mac_dot_sequencer: RTL and testbench

//  Drives the Q8.8 MAC datapath. It streams a vector of pixel/weight pairs from two

---
 rtl/mac_dot_sequencer.sv | 173 +++++++++++++++++
 tb/tb_mac_dot_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_sequencer.sv
// Controller in front of one Q8.8 MAC. It streams pixel/weight pairs from two
// synchronous-read buffers, closes the accumulate loop and returns the dot product.
module mac_dot_sequencer #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic [ADDR_W-1:0] pix_base,
    input  logic [ADDR_W-1:0] wgt_base,
    input  logic [DATA_W-1:0] bias,
    output logic              busy,
    output logic              mem_en,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [ADDR_W-1:0] wgt_addr,
    input  logic [DATA_W-1:0] pix_data,
    input  logic [DATA_W-1:0] wgt_data,
    output logic [DATA_W-1:0] mac_pixel,
    output logic [DATA_W-1:0] mac_weight,
    output logic [DATA_W-1:0] mac_accum,
    input  logic [DATA_W-1:0] mac_result,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] pix_base_q, pix_base_d;
    logic [ADDR_W-1:0] wgt_base_q, wgt_base_d;
    logic [DATA_W-1:0] bias_q, bias_d;
    logic              busy_q, busy_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic [ADDR_W-1:0] wgt_addr_q, wgt_addr_d;
    logic              term_valid_q, term_valid_d;
    logic              term_first_q, term_first_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            pix_base_q   <= '0;
            wgt_base_q   <= '0;
            bias_q       <= '0;
            busy_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            pix_addr_q   <= '0;
            wgt_addr_q   <= '0;
            term_valid_q <= 1'b0;
            term_first_q <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            pix_base_q   <= pix_base_d;
            wgt_base_q   <= wgt_base_d;
            bias_q       <= bias_d;
            busy_q       <= busy_d;
            mem_en_q     <= mem_en_d;
            pix_addr_q   <= pix_addr_d;
            wgt_addr_q   <= wgt_addr_d;
            term_valid_q <= term_valid_d;
            term_first_q <= term_first_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // Next-state and registered-output logic; read data trails mem_en by one cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        pix_base_d   = pix_base_q;
        wgt_base_d   = wgt_base_q;
        bias_d       = bias_q;
        busy_d       = busy_q;
        mem_en_d     = mem_en_q;
        pix_addr_d   = pix_addr_q;
        wgt_addr_d   = wgt_addr_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        term_valid_d = mem_en_q;
        term_first_d = mem_en_q && (cnt_q == '0);

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d      = len;
                    pix_base_d = pix_base;
                    wgt_base_d = wgt_base;
                    bias_d     = bias;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    if (len == '0) begin
                        out_data_d = bias;
                        state_d    = OUT;
                    end else begin
                        mem_en_d   = 1'b1;
                        pix_addr_d = pix_base;
                        wgt_addr_d = wgt_base;
                        state_d    = FETCH;
                    end
                end
            end
            FETCH: begin
                if (cnt_q == len_q - ADDR_W'(1)) begin
                    mem_en_d = 1'b0;
                    state_d  = DRAIN;
                end else begin
                    cnt_d      = cnt_q + ADDR_W'(1);
                    mem_en_d   = 1'b1;
                    pix_addr_d = pix_base_q + cnt_q + ADDR_W'(1);
                    wgt_addr_d = wgt_base_q + cnt_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // Once the last term has left the read pipe, mac_result is final.
                if (!term_valid_q) begin
                    out_data_d  = mac_result;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // MAC feed: data straight from the buffers; accum idles at zero outside an operation.
    always_comb begin
        mac_pixel  = '0;
        mac_weight = '0;
        mac_accum  = busy_q ? mac_result : '0;
        if (term_valid_q) begin
            mac_pixel  = pix_data;
            mac_weight = wgt_data;
            mac_accum  = term_first_q ? bias_q : mac_result;
        end
    end

    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign pix_addr  = pix_addr_q;
    assign wgt_addr  = wgt_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer with buffer and MAC models; results are compared
// against a dot product computed directly from the buffer contents.
module tb_mac_dot_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic [7:0]  pix_base;
    logic [7:0]  wgt_base;
    logic [15:0] bias;
    logic        busy;
    logic        mem_en;
    logic [7:0]  pix_addr;
    logic [7:0]  wgt_addr;
    logic [15:0] pix_data;
    logic [15:0] wgt_data;
    logic [15:0] mac_pixel;
    logic [15:0] mac_weight;
    logic [15:0] mac_accum;
    logic [15:0] mac_result;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    logic [15:0] pix_mem [256];
    logic [15:0] wgt_mem [256];

    int checks;
    int errors;

    mac_dot_sequencer #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .pix_base   (pix_base),
        .wgt_base   (wgt_base),
        .bias       (bias),
        .busy       (busy),
        .mem_en     (mem_en),
        .pix_addr   (pix_addr),
        .wgt_addr   (wgt_addr),
        .pix_data   (pix_data),
        .wgt_data   (wgt_data),
        .mac_pixel  (mac_pixel),
        .mac_weight (mac_weight),
        .mac_accum  (mac_accum),
        .mac_result (mac_result),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read buffers
    always @(posedge clk) begin
        if (mem_en) begin
            pix_data <= pix_mem[pix_addr];
            wgt_data <= wgt_mem[wgt_addr];
        end
    end

    // Q8.8 MAC with registered result
    logic signed [31:0] mac_prod;
    logic [15:0]        mac_term;
    assign mac_prod = 32'($signed(mac_pixel)) * 32'($signed(mac_weight));
    assign mac_term = 16'(mac_prod >>> 8);
    always @(posedge clk) begin
        if (reset) mac_result <= 16'h0;
        else       mac_result <= mac_accum + mac_term;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_dot(input int n, input logic [7:0] pb,
                                            input logic [7:0] wb, input logic [15:0] b);
        logic [15:0]        acc;
        logic signed [31:0] p;
        acc = b;
        for (int i = 0; i < n; i++) begin
            p   = 32'($signed(pix_mem[pb + 8'(i)])) * 32'($signed(wgt_mem[wb + 8'(i)]));
            acc = acc + 16'(p >>> 8);
        end
        return acc;
    endfunction

    task automatic fill_const(input logic [7:0] pb, input logic [7:0] wb, input int n,
                              input logic [15:0] pv, input logic [15:0] wv);
        for (int i = 0; i < n; i++) begin
            pix_mem[pb + 8'(i)] = pv;
            wgt_mem[wb + 8'(i)] = wv;
        end
    endtask

    task automatic fill_rand(input logic [7:0] pb, input logic [7:0] wb, input int n);
        for (int i = 0; i < n; i++) begin
            pix_mem[pb + 8'(i)] = 16'($urandom);
            wgt_mem[wb + 8'(i)] = 16'($urandom);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},      32'(busy),       32'h0);
        chk({tag, "_mem_en"},    32'(mem_en),     32'h0);
        chk({tag, "_out_valid"}, 32'(out_valid),  32'h0);
        chk({tag, "_out_data"},  32'(out_data),   32'h0);
        chk({tag, "_pix_addr"},  32'(pix_addr),   32'h0);
        chk({tag, "_wgt_addr"},  32'(wgt_addr),   32'h0);
        chk({tag, "_mac_pixel"}, 32'(mac_pixel),  32'h0);
        chk({tag, "_mac_weight"},32'(mac_weight), 32'h0);
        chk({tag, "_mac_accum"}, 32'(mac_accum),  32'h0);
    endtask

    // One full dot product: start, stream, wait for out_valid, optional stall, handshake.
    task automatic run_dot(input string tag, input int n, input logic [7:0] pb,
                           input logic [7:0] wb, input logic [15:0] b, input int hold,
                           input bit poke, input int directed);
        logic [15:0] exp_v;
        int          k;
        int          issued;
        bit          addr_ok;
        exp_v = ref_dot(n, pb, wb, b);
        start = 1'b1; len = 8'(n); pix_base = pb; wgt_base = wb; bias = b;
        tick();
        start = 1'b0;
        len = 8'($urandom); pix_base = 8'($urandom); wgt_base = 8'($urandom); bias = 16'($urandom);
        chk({tag, "_busy_on_start"}, 32'(busy), 32'h1);
        issued = 0; addr_ok = 1'b1; k = 0;
        while (k < 600) begin
            if (mem_en) begin
                if (pix_addr !== pb + 8'(issued) || wgt_addr !== wb + 8'(issued)) addr_ok = 1'b0;
                issued++;
            end
            if (out_valid) break;
            if (poke) start = k[0];
            tick();
            k++;
        end
        start = 1'b0;
        chk({tag, "_valid_latency"}, 32'(k), 32'((n == 0) ? 1 : n + 2));
        chk({tag, "_mem_en_cycles"}, 32'(issued), 32'(n));
        chk({tag, "_addr_seq"},      32'(addr_ok), 32'h1);
        chk({tag, "_out_data"},      32'(out_data), 32'(exp_v));
        if (directed >= 0) chk({tag, "_directed"}, 32'(out_data), 32'(directed));
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            start = poke;
            tick();
            start = 1'b0;
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'h1);
            chk({tag, "_hold_data"},  32'(out_data),  32'(exp_v));
        end
        out_ready = 1'b1;
        start = poke;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'h0);
        chk({tag, "_busy_drop"},  32'(busy),      32'h0);
        tick();
        chk({tag, "_stays_idle"}, 32'(busy), 32'h0);
    endtask

    initial begin
        logic [7:0] rpb;
        logic [7:0] rwb;
        int         rn;
        checks = 0; errors = 0;
        reset = 1'b1; start = 1'b0; len = '0; pix_base = '0; wgt_base = '0;
        bias = '0; out_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            pix_mem[i] = 16'h0;
            wgt_mem[i] = 16'h0;
        end
        tick(); tick();
        chk_idle("reset");
        reset = 1'b0;
        tick();

        fill_const(8'h10, 8'h40, 4, 16'h0100, 16'h0200);
        run_dot("t1_basic", 4, 8'h10, 8'h40, 16'h0000, 0, 1'b0, 16'h0800);

        run_dot("t2_len0", 0, 8'h33, 8'h77, 16'h0180, 2, 1'b0, 16'h0180);

        fill_const(8'h20, 8'h50, 3, 16'h0080, 16'h0200);
        run_dot("t3_stall", 3, 8'h20, 8'h50, 16'h0100, 5, 1'b1, 16'h0400);

        fill_rand(8'hFE, 8'hFC, 4);
        run_dot("t4_wrap", 4, 8'hFE, 8'hFC, 16'h0000, 1, 1'b0, -1);

        // Abort mid-fetch: reset while term index 3 is on the buffer address bus
        fill_rand(8'h60, 8'h90, 8);
        start = 1'b1; len = 8'd8; pix_base = 8'h60; wgt_base = 8'h90; bias = 16'h1234;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("t5_pre_reset_addr", 32'(pix_addr), 32'h63);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("t5_abort");
        tick();
        chk("t5_still_idle", 32'(busy), 32'h0);
        fill_const(8'h00, 8'h00, 1, 16'h0100, 16'h0100);
        run_dot("t5_restart", 1, 8'h00, 8'h00, 16'h0000, 0, 1'b0, 16'h0100);

        fill_const(8'hA0, 8'hB0, 2, 16'h7F00, 16'h0200);
        run_dot("t6_overflow", 2, 8'hA0, 8'hB0, 16'h0000, 0, 1'b0, 16'hFC00);

        for (int r = 0; r < 8; r++) begin
            rn  = int'($urandom_range(1, 24));
            rpb = 8'($urandom);
            rwb = 8'($urandom);
            fill_rand(rpb, rwb, rn);
            run_dot("rand", rn, rpb, rwb, 16'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom), -1);
        end

        fill_rand(8'hF0, 8'hE0, 255);
        run_dot("max_len", 255, 8'hF0, 8'hE0, 16'($urandom), 1, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
